regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DW, default 16, data width in bits of each register and of data_in/data_out.
REQ-002 Parameter: AW, default 3, register index width; register count SHALL be 2**AW (default 8, R0..R7).
REQ-003 Port: clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: data_in  input  DW  write data.
REQ-006 Port: writenum  input  AW  index of the register to be written.
REQ-007 Port: write  input  1  write enable, active-high.
REQ-008 Port: readnum  input  AW  index of the register to be read.
REQ-009 Port: data_out  output  DW  contents of the register selected by readnum.
REQ-010 The block SHALL use one clock, clk, with a synchronous, active-high reset, reset.

Function
REQ-011 Storage SHALL be 2**AW independent registers, each DW bits wide.
REQ-012 On a rising clk edge with reset=0 and write=1, the register indexed by writenum SHALL load data_in; all other registers SHALL hold.
REQ-013 On a rising clk edge with reset=0 and write=0, all registers SHALL hold, regardless of data_in or writenum.
REQ-014 Writes of any value, including all-zeros, SHALL load normally; a zero write SHALL overwrite a nonzero value.
REQ-015 data_out SHALL be a purely combinational function of readnum and the current register contents, with no clock latency and no output register.
REQ-016 A readnum change SHALL be reflected on data_out in the same cycle.
REQ-017 The read path SHALL NOT bypass from data_in; when readnum equals writenum during a write, data_out SHALL show the old value until the edge and the new value immediately after it.
REQ-018 Write latency SHALL be one edge: a value written at edge N SHALL be readable directly after edge N.
REQ-019 Changes to data_in, writenum or write between clock edges SHALL NOT affect stored state.
REQ-020 Every writenum value 0..2**AW-1 SHALL be valid, and there SHALL be no hardwired-zero register.

Reset
REQ-021 On a rising clk edge with reset=1, all registers SHALL clear to 0.
REQ-022 Reset SHALL take precedence over a simultaneous write.
REQ-023 After reset, data_out SHALL be 0 for every readnum.
REQ-024 Reset asserted between edges SHALL have no effect until the next rising edge.

Structure
REQ-025 DW and AW defaults SHALL live in the shared CPU package as constants, so that the datapath and the regfile use the same values.
REQ-026 The write-index decode SHALL be a one-hot decoder of writenum, gated by write, producing one load enable per register.
REQ-027 The read path SHALL be a (2**AW):1 multiplexer selected by readnum, implemented as a one-hot decoder plus an AND-OR mux.
REQ-028 Each register SHALL be an instance of one sub-module, load_reg: a DW-bit flop with load enable and synchronous clear.
REQ-029 There SHALL be no latches and no combinational loops.

Verification
REQ-030 For each index i=0..7: write=1, writenum=i, data_in=0x002A (R0), 0x0027, 0x01E3, 0x9122, 0x0001, 0x0004, 0x0038, 0x1000 (R7); readnum=i -> data_out equals that value right after the edge.
REQ-031 Hold: after REQ-030, write=0, data_in=0, two edges -> data_out is unchanged (nonzero).
REQ-032 Zero overwrite: write=1, data_in=0, same index, one edge -> data_out=0x0000.
REQ-033 Isolation: write 0xFFFF to R3, then read R0..R7 -> only R3 reads 0xFFFF, and no other register has changed.
REQ-034 Reset: fill all registers, assert reset with write=1, writenum=5, data_in=0xBEEF, one edge -> every readnum returns 0x0000.
REQ-035 Read timing: with readnum=writenum=2, R2=0x1111, write=1, data_in=0x2222 -> data_out is 0x1111 before the edge and 0x2222 after it; readnum changes update data_out with no clock.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared CPU constants: datapath and register file take their default
// widths from here so both stay in step.
package regfile_pkg;
  localparam int unsigned REGFILE_DW = 16;
  localparam int unsigned REGFILE_AW = 3;
endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one write port and one combinational read port.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DW = REGFILE_DW,
  parameter int unsigned AW = REGFILE_AW
) ();
  logic [DW-1:0] data_in;
  logic [AW-1:0] writenum;
  logic          write;
  logic [AW-1:0] readnum;
  logic [DW-1:0] data_out;

  modport master (
    output data_in, writenum, write, readnum,
    input  data_out
  );

  modport slave (
    input  data_in, writenum, write, readnum,
    output data_out
  );
endinterface

// File: rtl/regfile_load_reg.sv
// DW-bit register with load enable and synchronous clear (clear wins).
module load_reg #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ld,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/regfile.sv
// 2**AW x DW register file: decoded write enables, one-hot AND-OR read mux,
// no bypass from data_in to data_out.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DW = REGFILE_DW,
  parameter int unsigned AW = REGFILE_AW
) (
  input logic      clk,
  input logic      reset,
  regfile_if.slave bus
);
  localparam int unsigned NREG = 1 << AW;

  logic [NREG-1:0] load_en;
  logic [NREG-1:0] read_sel;
  logic [DW-1:0]   reg_val [NREG];
  logic [DW-1:0]   rd_data;

  always_comb begin
    load_en  = '0;
    read_sel = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      load_en[i]  = bus.write && (bus.writenum == AW'(i));
      read_sel[i] = (bus.readnum == AW'(i));
    end
  end

  // Exactly one read_sel bit is set, so OR-ing the gated words selects one.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      rd_data = rd_data | (reg_val[i] & {DW{read_sel[i]}});
    end
  end

  assign bus.data_out = rd_data;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    load_reg #(.DW(DW)) u_reg (
      .clk (clk),
      .clr (reset),
      .ld  (load_en[g]),
      .d   (bus.data_in),
      .q   (reg_val[g])
    );
  end
endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed cases plus randomized traffic
// checked against an array model of the register contents.
module tb_regfile;
  import regfile_pkg::*;

  localparam int unsigned DW = REGFILE_DW;
  localparam int unsigned AW = REGFILE_AW;
  localparam int unsigned NREG = 1 << AW;

  typedef struct {
    string         name;
    logic [DW-1:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset;
  regfile_if #(.DW(DW), .AW(AW)) bus ();

  regfile #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [NREG];
  sb_entry_t     sb [$];
  event          probe_ev;
  int            checks = 0;
  int            errors = 0;

  // Monitor: compare data_out at each falling edge or explicit probe.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk or probe_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.data_out !== e.exp) begin
          errors++;
          $display("FAIL %s: data_out=%h expected=%h", e.name, bus.data_out, e.exp);
        end
      end
    end
  end

  // Called at posedge+1: drive, queue the pre-edge read, then apply the edge to the model.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] wn,
                      input logic [DW-1:0] din, input logic [AW-1:0] rn, input string nm);
    reset        = r;
    bus.write    = w;
    bus.writenum = wn;
    bus.data_in  = din;
    bus.readnum  = rn;
    sb.push_back('{nm, model[rn]});
    @(posedge clk);
    if (r) begin
      foreach (model[i]) model[i] = '0;
    end else if (w) begin
      model[wn] = din;
    end
    #1;
  endtask

  // Mid-cycle read with no clock edge involved; at most two per half-cycle.
  task automatic probe(input logic [AW-1:0] rn, input string nm);
    reset       = 1'b0;
    bus.write   = 1'b0;
    bus.readnum = rn;
    #1;
    sb.push_back('{nm, model[rn]});
    -> probe_ev;
    #1;
  endtask

  task automatic realign();
    reset     = 1'b0;
    bus.write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string nm);
    for (int i = 0; i < int'(NREG); i++) step(1'b0, 1'b0, '0, '0, AW'(i), nm);
  endtask

  logic [DW-1:0] vals [NREG];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vals = '{16'h002A, 16'h0027, 16'h01E3, 16'h9122,
             16'h0001, 16'h0004, 16'h0038, 16'h1000};
    foreach (model[i]) model[i] = '0;
    reset = 1'b1; bus.write = 1'b0; bus.writenum = '0; bus.data_in = '0; bus.readnum = '0;
    @(posedge clk); #1;

    read_all("reset_zero");

    for (int i = 0; i < int'(NREG); i++) begin
      step(1'b0, 1'b1, AW'(i), vals[i], AW'(i), "write_pre_edge");
      step(1'b0, 1'b0, '0, 16'hFFFF, AW'(i), "write_readback");
    end

    step(1'b0, 1'b0, 3'd7, '0, 3'd7, "hold_edge1");
    step(1'b0, 1'b0, 3'd1, '0, 3'd7, "hold_edge2");
    step(1'b0, 1'b0, 3'd0, '0, 3'd7, "hold_value");

    step(1'b0, 1'b1, 3'd7, '0, 3'd7, "zero_pre_edge");
    step(1'b0, 1'b0, 3'd7, '0, 3'd7, "zero_overwrite");

    step(1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd0, "iso_write");
    read_all("isolation");

    reset = 1'b1; bus.write = 1'b0; bus.readnum = 3'd3;
    #1;
    sb.push_back('{"reset_mid_cycle", model[3]});
    -> probe_ev;
    #1;
    reset = 1'b0;
    realign();
    read_all("after_glitch_reset");

    step(1'b1, 1'b1, 3'd5, 16'hBEEF, 3'd5, "reset_pre_edge");
    read_all("reset_over_write");

    step(1'b0, 1'b1, 3'd2, 16'h1111, 3'd2, "r2_setup");
    step(1'b0, 1'b1, 3'd2, 16'h2222, 3'd2, "r2_old_before_edge");
    probe(3'd0, "readnum_change_r0");
    probe(3'd2, "readnum_change_r2");
    realign();
    step(1'b0, 1'b0, 3'd2, '0, 3'd2, "r2_new_after_edge");

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, NREG - 1)), DW'($urandom),
           AW'($urandom_range(0, NREG - 1)), "random");
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
